detect_event_monitor: RTL
=========================

DETECT_EVENT_MONITOR -- requirements
Module: detect_event_monitor

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8: width of the event counter.
REQ-002 The module SHALL have parameter WINDOW, default 16: burst window length in clock cycles.
REQ-003 The module SHALL have parameter THRESH, default 3: number of detections within one window that constitutes a burst.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port detect, input, 1 bit: Moore detector output; each high cycle is one detection event.
REQ-007 The module SHALL have port clr, input, 1 bit: synchronous clear of count, overflow and missed.
REQ-008 The module SHALL have port irq_ack, input, 1 bit: acknowledge of the pending burst interrupt.
REQ-009 The module SHALL have port count, output, CNT_W bits: saturating total of detections.
REQ-010 The module SHALL have port overflow, output, 1 bit: sticky; set when a detection arrives with count at all-ones.
REQ-011 The module SHALL have port irq, output, 1 bit: burst interrupt, level, held until acknowledged.
REQ-012 The module SHALL have port missed, output, 1 bit: sticky; set when a burst occurs while irq is already pending.

Function
REQ-013 Each cycle with detect=1 and clr=0 SHALL increment count by 1, visible the next cycle; at all-ones count SHALL hold and overflow SHALL set.
REQ-014 clr=1 SHALL zero count, overflow and missed next cycle; a detect in the same cycle SHALL be discarded (clr wins); the window and irq FSMs SHALL be unaffected by clr.
REQ-015 Window FSM states: W_IDLE, W_OPEN. In W_IDLE, detect=1 SHALL move to W_OPEN with win_cyc=1 and hits=1.
REQ-016 In W_OPEN, win_cyc SHALL increment every cycle and hits SHALL increment on detect; when win_cyc reaches WINDOW, the FSM SHALL return to W_IDLE, and a detect in that closing cycle SHALL NOT open a new window.
REQ-017 A burst event SHALL fire in the cycle hits increments to THRESH; after that, the window SHALL close immediately (to W_IDLE), giving at most one burst per window.
REQ-018 irq FSM states: I_IDLE, I_PEND. A burst in I_IDLE SHALL assert irq the next cycle (1-cycle latency) and enter I_PEND.
REQ-019 In I_PEND, irq_ack=1 SHALL deassert irq next cycle and return to I_IDLE; irq_ack in I_IDLE SHALL be ignored.
REQ-020 A burst arriving in I_PEND SHALL set missed, including when it arrives in the same cycle as irq_ack (ack wins, burst lost); irq SHALL then drop.
REQ-021 hits and win_cyc SHALL be sized to hold WINDOW without wrap; THRESH greater than WINDOW means no burst ever fires.

Reset
REQ-022 While rst_n=0, count SHALL be 0, overflow 0, irq 0 and missed 0, the window FSM SHALL be in W_IDLE and the irq FSM in I_IDLE, all applied asynchronously.
REQ-023 Deassertion of rst_n SHALL take effect at the next clock edge; reset mid-window or mid-pending SHALL discard all progress.

Structure
REQ-024 The window and irq state encodings and the default parameter values SHALL live in the shared package seq_det_pkg.
REQ-025 The window FSM SHALL be the sub-module burst_window (inputs clk, rst_n, detect; output burst pulse); counter, stickies and irq FSM SHALL stay in the top.
REQ-026 The block SHALL connect directly to the detect output of the overlapping 110110 detector with no retiming.

Verification
REQ-027 With rst_n low and random detect, the bench SHALL check all outputs at 0; after release, 5 isolated detect pulses SHALL give count=5, irq=0.
REQ-028 With count preset to 254 via 254 detects, 3 more detects SHALL give count=255 and overflow=1; clr SHALL then give count=0 and overflow=0.
REQ-029 The stream 110110110 fed through the detector (detects 3 cycles apart, within WINDOW=16) and then a third detect SHALL raise irq one cycle after the third detect; irq SHALL stay high until irq_ack, then drop the next cycle.
REQ-030 Detects at cycles 0, 10 and 20 (span exceeding WINDOW=16) SHALL produce no irq and count=3.
REQ-031 A second burst while irq is pending, and a burst in the same cycle as irq_ack, SHALL each set missed=1 and leave irq=0 after the ack.
REQ-032 Pulling rst_n low while in W_OPEN with hits=2 and then releasing it, followed by one detect, SHALL produce no irq.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared encodings and default sizing for the detection-event monitor.
package seq_det_pkg;
    localparam int CNT_W_DEF  = 8;
    localparam int WINDOW_DEF = 16;
    localparam int THRESH_DEF = 3;

    typedef enum logic {W_IDLE, W_OPEN} win_state_t;
    typedef enum logic {I_IDLE, I_PEND} irq_state_t;
endpackage

// File: rtl/burst_window.sv
// Burst window: pulses burst when THRESH detections land within WINDOW cycles.
module burst_window
    import seq_det_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic detect,
    output logic burst
);
    localparam int HW = $clog2(WINDOW + 1);
    localparam logic [HW-1:0] ONE = HW'(1);

    win_state_t    st, st_n;
    logic [HW-1:0] win_cyc, win_cyc_n;
    logic [HW-1:0] hits, hits_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= W_IDLE;
            win_cyc <= '0;
            hits    <= '0;
        end else begin
            st      <= st_n;
            win_cyc <= win_cyc_n;
            hits    <= hits_n;
        end
    end

    // The window spans WINDOW cycles counting the opening cycle; the closing
    // cycle still counts a hit but never reopens.
    always_comb begin
        st_n      = st;
        win_cyc_n = win_cyc;
        hits_n    = hits;
        burst     = 1'b0;
        case (st)
            W_IDLE: begin
                if (detect) begin
                    if (THRESH == 1) begin
                        burst = 1'b1;
                    end else if (WINDOW > 1) begin
                        st_n      = W_OPEN;
                        win_cyc_n = ONE;
                        hits_n    = ONE;
                    end
                end
            end
            W_OPEN: begin
                win_cyc_n = win_cyc + ONE;
                if (detect) hits_n = hits + ONE;
                if (detect && (int'(hits) + 1 == THRESH)) begin
                    burst = 1'b1;
                    st_n  = W_IDLE;
                end else if (int'(win_cyc) + 1 >= WINDOW) begin
                    st_n = W_IDLE;
                end
            end
            default: st_n = W_IDLE;
        endcase
    end
endmodule

// File: rtl/detect_event_monitor.sv
// Counts detector hits, flags overflow, and raises a held interrupt on bursts.
module detect_event_monitor
    import seq_det_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             detect,
    input  logic             clr,
    input  logic             irq_ack,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             irq,
    output logic             missed
);
    logic       burst;
    logic       miss_ev;
    irq_state_t ist, ist_n;

    burst_window #(.WINDOW(WINDOW), .THRESH(THRESH)) u_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .detect (detect),
        .burst  (burst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
            missed   <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
            missed   <= 1'b0;
        end else begin
            if (detect) begin
                if (&count) overflow <= 1'b1;
                else        count    <= count + 1'b1;
            end
            if (miss_ev) missed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ist <= I_IDLE;
        else        ist <= ist_n;
    end

    // A burst while pending is lost even if the ack lands in the same cycle.
    always_comb begin
        ist_n   = ist;
        miss_ev = 1'b0;
        case (ist)
            I_IDLE: if (burst) ist_n = I_PEND;
            I_PEND: begin
                if (burst)   miss_ev = 1'b1;
                if (irq_ack) ist_n   = I_IDLE;
            end
            default: ist_n = I_IDLE;
        endcase
    end

    assign irq = (ist == I_PEND);
endmodule
